// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared across the five-stage MIPS pipeline.
//   CTRL_W          width of the decoded control bundle
//   CTRL_*          bit positions inside that bundle
//   REG_ZERO        hard-wired zero register number
//   reg_idx_t       register-number type
package mips_pkg;

  localparam int unsigned CTRL_W = 10;

  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_READ   = 1;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 3;
  localparam int unsigned CTRL_ALU_OP_LO  = 4;
  localparam int unsigned CTRL_ALU_OP_HI  = 7;
  localparam int unsigned CTRL_ALU_SRC    = 8;
  localparam int unsigned CTRL_REG_DST    = 9;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_u.sv
// hazard_u: combinational load-use hazard detection.
// Flags the ID instruction when the instruction in EX is a load whose
// destination (Rt) is a source of the ID instruction. Register 0 never hazards.
// Ports:
//   i_idex_mem_read  EX instruction is a load
//   i_idex_rt        destination register of the EX load
//   i_ifid_rs        Rs of the ID instruction
//   i_ifid_rt        Rt of the ID instruction
//   i_ifid_uses_rt   ID instruction reads Rt as a source
//   o_hazard         load-use hazard
module hazard_u
  import mips_pkg::*;
(
  input  logic     i_idex_mem_read,
  input  reg_idx_t i_idex_rt,
  input  reg_idx_t i_ifid_rs,
  input  reg_idx_t i_ifid_rt,
  input  logic     i_ifid_uses_rt,
  output logic     o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  always_comb begin
    w_rs_match = (i_idex_rt == i_ifid_rs);
    w_rt_match = i_ifid_uses_rt && (i_idex_rt == i_ifid_rt);
    o_hazard   = i_idex_mem_read && (i_idex_rt != REG_ZERO) && (w_rs_match || w_rt_match);
  end

endmodule

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with load-use bubble insertion,
// branch flush handling and external memory stall.
// Optional performance counters are built when IDEX_PERF_CNT_EN is defined.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   IFID_Rs/Rt/Rd             register numbers of the ID instruction
//   IFID_uses_rt              ID instruction reads Rt
//   IFID_RD1/RD2/imm          operands from ID
//   IFID_ctrl                 decoded control from ID
//   flush                     taken branch/jump kills the ID instruction
//   ext_stall                 memory not ready, whole pipeline freezes
//   IDEX_*                    registered fields toward EX (ctrl all-zero = bubble)
//   pc_write, IFID_write      enables for PC and IF/ID (combinational)
//   bubble_cnt, stall_cnt     saturating performance counters (IDEX_PERF_CNT_EN)
module idex_stage
  import mips_pkg::*;
#(
  parameter int unsigned CTRL_W = 10
`ifdef IDEX_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        IFID_Rs,
  input  logic [4:0]        IFID_Rt,
  input  logic [4:0]        IFID_Rd,
  input  logic              IFID_uses_rt,
  input  logic [31:0]       IFID_RD1,
  input  logic [31:0]       IFID_RD2,
  input  logic [31:0]       IFID_imm,
  input  logic [CTRL_W-1:0] IFID_ctrl,
  input  logic              flush,
  input  logic              ext_stall,
  output logic [4:0]        IDEX_Rs,
  output logic [4:0]        IDEX_Rt,
  output logic [4:0]        IDEX_Rd,
  output logic [31:0]       IDEX_RD1,
  output logic [31:0]       IDEX_RD2,
  output logic [31:0]       IDEX_imm,
  output logic [CTRL_W-1:0] IDEX_ctrl,
  output logic              pc_write,
  output logic              IFID_write
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [31:0]       r_rd1;
  logic [31:0]       r_rd2;
  logic [31:0]       r_imm;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_pend_flush;

  logic w_hazard;
  logic w_kill;
  logic w_bubble;

  hazard_u u_hazard (
    .i_idex_mem_read (r_ctrl[CTRL_MEM_READ]),
    .i_idex_rt       (r_rt),
    .i_ifid_rs       (IFID_Rs),
    .i_ifid_rt       (IFID_Rt),
    .i_ifid_uses_rt  (IFID_uses_rt),
    .o_hazard        (w_hazard)
  );

  // A pending or live flush kills the ID instruction, so a hazard against it
  // needs no freeze; the bubble comes from the kill instead.
  always_comb begin
    w_kill     = flush || r_pend_flush;
    w_bubble   = w_kill || w_hazard;
    pc_write   = !ext_stall && !(w_hazard && !w_kill);
    IFID_write = pc_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_ctrl       <= '0;
      r_pend_flush <= 1'b0;
    end else if (ext_stall) begin
      if (flush) r_pend_flush <= 1'b1;
    end else begin
      r_rs         <= IFID_Rs;
      r_rt         <= IFID_Rt;
      r_rd         <= IFID_Rd;
      r_rd1        <= IFID_RD1;
      r_rd2        <= IFID_RD2;
      r_imm        <= IFID_imm;
      r_ctrl       <= w_bubble ? '0 : IFID_ctrl;
      r_pend_flush <= 1'b0;
    end
  end

  assign IDEX_Rs   = r_rs;
  assign IDEX_Rt   = r_rt;
  assign IDEX_Rd   = r_rd;
  assign IDEX_RD1  = r_rd1;
  assign IDEX_RD2  = r_rd2;
  assign IDEX_imm  = r_imm;
  assign IDEX_ctrl = r_ctrl;

`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else if (ext_stall) begin
      if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
    end else if (w_bubble) begin
      if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_idex_stage.sv
module tb_idex_stage;
  import mips_pkg::*;

  localparam int unsigned CW    = 10;
  localparam int unsigned NW    = 4;
  localparam int          CMAX  = (1 << NW) - 1;
  localparam logic [CW-1:0] C_LW  = 10'h00B;
  localparam logic [CW-1:0] C_ADD = 10'h2A1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    IFID_Rs, IFID_Rt, IFID_Rd;
  logic          IFID_uses_rt;
  logic [31:0]   IFID_RD1, IFID_RD2, IFID_imm;
  logic [CW-1:0] IFID_ctrl;
  logic          flush, ext_stall;
  logic [4:0]    IDEX_Rs, IDEX_Rt, IDEX_Rd;
  logic [31:0]   IDEX_RD1, IDEX_RD2, IDEX_imm;
  logic [CW-1:0] IDEX_ctrl;
  logic          pc_write, IFID_write;
`ifdef IDEX_PERF_CNT_EN
  logic [NW-1:0] bubble_cnt, stall_cnt;
`endif

  idex_stage #(
    .CTRL_W (CW)
`ifdef IDEX_PERF_CNT_EN
    , .CNT_W (NW)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .IFID_Rs      (IFID_Rs),
    .IFID_Rt      (IFID_Rt),
    .IFID_Rd      (IFID_Rd),
    .IFID_uses_rt (IFID_uses_rt),
    .IFID_RD1     (IFID_RD1),
    .IFID_RD2     (IFID_RD2),
    .IFID_imm     (IFID_imm),
    .IFID_ctrl    (IFID_ctrl),
    .flush        (flush),
    .ext_stall    (ext_stall),
    .IDEX_Rs      (IDEX_Rs),
    .IDEX_Rt      (IDEX_Rt),
    .IDEX_Rd      (IDEX_Rd),
    .IDEX_RD1     (IDEX_RD1),
    .IDEX_RD2     (IDEX_RD2),
    .IDEX_imm     (IDEX_imm),
    .IDEX_ctrl    (IDEX_ctrl),
    .pc_write     (pc_write),
    .IFID_write   (IFID_write)
`ifdef IDEX_PERF_CNT_EN
    ,
    .bubble_cnt   (bubble_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: what EX is supposed to hold, plus the remembered flush.
  logic [4:0]    m_rs, m_rt, m_rd;
  logic [31:0]   m_rd1, m_rd2, m_imm;
  logic [CW-1:0] m_ctrl;
  bit            m_pend;
  int            m_bub, m_stl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic ut, input logic [CW-1:0] c, input logic fl, input logic st,
                       input logic r);
    IFID_Rs = rs; IFID_Rt = rt; IFID_Rd = rd; IFID_uses_rt = ut;
    IFID_RD1 = $urandom; IFID_RD2 = $urandom; IFID_imm = $urandom;
    IFID_ctrl = c; flush = fl; ext_stall = st; rst = r;
  endtask

  // One clock: check the combinational enables, advance the model, check EX.
  task automatic cycle();
    bit src_dep, haz, kill, exp_pcw;
    src_dep = (m_rt == IFID_Rs) || (IFID_uses_rt && m_rt == IFID_Rt);
    haz     = m_ctrl[CTRL_MEM_READ] && (m_rt != REG_ZERO) && src_dep;
    kill    = flush || m_pend;
    exp_pcw = !ext_stall && (!haz || kill);
    #1;
    chk("pc_write", {63'd0, pc_write}, {63'd0, exp_pcw});
    chk("IFID_write", {63'd0, IFID_write}, {63'd0, exp_pcw});
    if (rst) begin
      {m_rs, m_rt, m_rd, m_rd1, m_rd2, m_imm, m_ctrl} = '0;
      m_pend = 0; m_bub = 0; m_stl = 0;
    end else if (ext_stall) begin
      if (flush) m_pend = 1;
      m_stl = (m_stl + 1 > CMAX) ? CMAX : m_stl + 1;
    end else begin
      m_rs = IFID_Rs; m_rt = IFID_Rt; m_rd = IFID_Rd;
      m_rd1 = IFID_RD1; m_rd2 = IFID_RD2; m_imm = IFID_imm;
      m_ctrl = (kill || haz) ? '0 : IFID_ctrl;
      if (kill || haz) m_bub = (m_bub + 1 > CMAX) ? CMAX : m_bub + 1;
      m_pend = 0;
    end
    @(posedge clk);
    #1;
    chk("IDEX_regs", {49'd0, IDEX_Rs, IDEX_Rt, IDEX_Rd}, {49'd0, m_rs, m_rt, m_rd});
    chk("IDEX_RD1", {32'd0, IDEX_RD1}, {32'd0, m_rd1});
    chk("IDEX_RD2", {32'd0, IDEX_RD2}, {32'd0, m_rd2});
    chk("IDEX_imm", {32'd0, IDEX_imm}, {32'd0, m_imm});
    chk("IDEX_ctrl", {54'd0, IDEX_ctrl}, {54'd0, m_ctrl});
`ifdef IDEX_PERF_CNT_EN
    chk("bubble_cnt", {60'd0, bubble_cnt}, 64'(m_bub));
    chk("stall_cnt", {60'd0, stall_cnt}, 64'(m_stl));
`endif
  endtask

  typedef struct {
    logic [4:0] ld_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ut;
    logic       fl;
    logic       exp_pcw;
    logic       exp_bubble;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};  // classic lw/add
    vecs[1] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};  // r0 never hazards
    vecs[2] = '{5'd9, 5'd1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0};  // Rt not a source
    vecs[3] = '{5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1};  // Rt is a source
    vecs[4] = '{5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1};  // flush beats hazard
    vecs[5] = '{5'd8, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0};  // unrelated regs

    // Reset state
    drive(5'd1, 5'd2, 5'd3, 1'b1, C_ADD, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("reset_ctrl", {54'd0, IDEX_ctrl}, 64'd0);
    chk("reset_rd1", {32'd0, IDEX_RD1}, 64'd0);

    // Table: nop, load, dependent instruction
    foreach (vecs[i]) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      cycle();
      drive(5'd2, vecs[i].ld_rt, 5'd0, 1'b0, C_LW, 1'b0, 1'b0, 1'b0);
      cycle();
      drive(vecs[i].rs, vecs[i].rt, 5'd12, vecs[i].ut, C_ADD, vecs[i].fl, 1'b0, 1'b0);
      #1;
      chk($sformatf("vec%0d_pcw", i), {63'd0, pc_write}, {63'd0, vecs[i].exp_pcw});
      cycle();
      chk($sformatf("vec%0d_ctrl", i), {54'd0, IDEX_ctrl},
          {54'd0, (vecs[i].exp_bubble ? 10'd0 : C_ADD)});
    end

    // lw/add: one bubble then the add enters EX
    drive(5'd2, 5'd8, 5'd0, 1'b0, C_LW, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(5'd8, 5'd5, 5'd10, 1'b0, C_ADD, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("lwadd_bubble", {54'd0, IDEX_ctrl}, 64'd0);
    chk("lwadd_pcw_after", {63'd0, pc_write}, 64'd1);
    cycle();
    chk("lwadd_add_in_ex", {49'd0, IDEX_Rs, IDEX_ctrl}, {49'd0, 5'd8, C_ADD});

    // Stall for 3 cycles, flush pulse in the middle, bubble on first free edge
    drive(5'd1, 5'd2, 5'd3, 1'b0, C_ADD, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(5'd4, 5'd5, 5'd6, 1'b0, C_LW, 1'b0, 1'b1, 1'b0);
    cycle();
    drive(5'd4, 5'd5, 5'd6, 1'b0, C_LW, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(5'd4, 5'd5, 5'd6, 1'b0, C_LW, 1'b0, 1'b1, 1'b0);
    cycle();
    chk("stall_hold", {54'd0, IDEX_ctrl}, {54'd0, C_ADD});
    drive(5'd4, 5'd5, 5'd6, 1'b0, C_LW, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("pend_flush_bubble", {54'd0, IDEX_ctrl}, 64'd0);

    // Reset during a hazard stall
    drive(5'd2, 5'd7, 5'd0, 1'b0, C_LW, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(5'd7, 5'd0, 5'd1, 1'b0, C_ADD, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("rst_hazard_ctrl", {54'd0, IDEX_ctrl}, 64'd0);
    drive(5'd7, 5'd0, 5'd1, 1'b0, C_ADD, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_hazard_pcw", {63'd0, pc_write}, 64'd1);
    cycle();

    // 20 flush bubbles: counter saturates
    for (int i = 0; i < 20; i++) begin
      drive(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, C_ADD, 1'b1, 1'b0, 1'b0);
      cycle();
    end
`ifdef IDEX_PERF_CNT_EN
    chk("bubble_sat", {60'd0, bubble_cnt}, 64'd15);
`endif

    // Random traffic on a small register range
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
            1'($urandom), (($urandom_range(0, 1) != 0) ? C_LW : 10'($urandom)),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 3));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
